// File: rtl/mux16_rr_scheduler_pkg.sv
// rtl/mux16_rr_scheduler_pkg.sv - shared constants, FSM states and round-robin pick for the mux scheduler
package mux16_rr_scheduler_pkg;

   localparam int NUM_REQ = 16;
   localparam int SEL_W   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // First set request searching ptr, ptr+1, ... ptr+15 with modulo-16 wrap.
   function automatic logic [SEL_W-1:0] rr_pick(
      input logic [SEL_W-1:0]   ptr,
      input logic [NUM_REQ-1:0] req
   );
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] result;
      logic             found;
      result = ptr;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + SEL_W'(k);
         if (!found && req[idx]) begin
            result = idx;
            found  = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/_16x1_mux_using_4x1_mux.sv
// rtl/_16x1_mux_using_4x1_mux.sv - 16:1 single-bit mux built from two tiers of 4:1 selects
module _16x1_mux_using_4x1_mux (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        out
);

   function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
      return d[s];
   endfunction

   logic [3:0] tier1;

   // Low select bits pick within each nibble, high bits pick the nibble.
   assign tier1[0] = mux4(in[3:0],   sel[1:0]);
   assign tier1[1] = mux4(in[7:4],   sel[1:0]);
   assign tier1[2] = mux4(in[11:8],  sel[1:0]);
   assign tier1[3] = mux4(in[15:12], sel[1:0]);
   assign out      = mux4(tier1,     sel[3:2]);

endmodule

// File: rtl/mux16_rr_scheduler.sv
// rtl/mux16_rr_scheduler.sv - round-robin burst scheduler driving a shared 16:1 mux select
module mux16_rr_scheduler
   import mux16_rr_scheduler_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] in,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   sel,
   output logic [NUM_REQ-1:0] gnt,
   output logic               out_valid,
   output logic               out_data,
   output logic [7:0]         beat_cnt
);

   localparam logic [7:0] LAST_CNT = 8'(BURST_LEN);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] winner;
   logic             xfer;
   logic             abort;
   logic             last_beat;

   assign winner    = rr_pick(ptr, req);
   assign abort     = !req[sel];
   assign xfer      = out_valid && out_ready && req[sel];
   assign last_beat = (beat_cnt + 8'd1) == LAST_CNT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         sel       <= '0;
         gnt       <= '0;
         out_valid <= 1'b0;
         beat_cnt  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req != '0) begin
                  state     <= ST_BUSY;
                  sel       <= winner;
                  gnt       <= NUM_REQ'(1) << winner;
                  out_valid <= 1'b1;
                  beat_cnt  <= 8'd0;
               end
            end
            ST_BUSY: begin
               // A dropped request ends the grant without counting a beat.
               if (abort) begin
                  state     <= ST_IDLE;
                  ptr       <= sel + SEL_W'(1);
                  gnt       <= '0;
                  out_valid <= 1'b0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (last_beat) begin
                     state     <= ST_IDLE;
                     ptr       <= sel + SEL_W'(1);
                     gnt       <= '0;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               gnt       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   _16x1_mux_using_4x1_mux u_mux (
      .in  (in),
      .sel (sel),
      .out (out_data)
   );

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// tb/tb_mux16_rr_scheduler.sv - directed self-checking bench for mux16_rr_scheduler
module tb_mux16_rr_scheduler;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] in_bits;
   logic        out_ready;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        out_valid;
   logic        out_data;
   logic [7:0]  beat_cnt;

   int errors = 0;
   int checks = 0;

   mux16_rr_scheduler #(.BURST_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in        (in_bits),
      .out_ready (out_ready),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 16'h0000;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_gnt"},   32'(gnt),       32'd0);
   endtask

   task automatic check_grant(input string tag, input int idx, input int cnt);
      check({tag, "_sel"},   32'(sel),       32'(idx));
      check({tag, "_gnt"},   32'(gnt),       32'(16'h0001 << idx));
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_cnt"},   32'(beat_cnt),  32'(cnt));
   endtask

   int rr_order[5] = '{0, 1, 15, 0, 1};

   initial begin
      rst_n     = 1'b0;
      req       = 16'hFFFF;
      in_bits   = 16'h0000;
      out_ready = 1'b1;

      // Reset held with every requester active
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_gnt",   32'(gnt),       32'd0);
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_sel",   32'(sel),       32'd0);
         check("rst_cnt",   32'(beat_cnt),  32'd0);
      end
      rst_n = 1'b1;
      step();
      check_grant("rst_first", 0, 0);

      // Single requester 5, data toggling on in[5]
      do_reset();
      req = 16'h0020;
      step();
      check_grant("single", 5, 0);
      for (int b = 0; b < 4; b++) begin
         in_bits = (b % 2 == 0) ? 16'h0020 : 16'hFFDF;
         #1;
         check("single_data", 32'(out_data), 32'((b % 2 == 0) ? 1 : 0));
         check("single_beat", 32'(beat_cnt), 32'(b));
         step();
      end
      check_idle("single_rel");
      check("single_total", 32'(beat_cnt), 32'd4);
      step();
      check_grant("single_regrant", 5, 0);
      req = 16'h0000;
      step();
      check_idle("single_abort");

      // Fairness and pointer wrap
      do_reset();
      req = 16'h8003;
      for (int g = 0; g < 5; g++) begin
         step();
         check("rr_sel", 32'(sel), 32'(rr_order[g]));
         repeat (4) step();
         check("rr_rel", 32'(out_valid), 32'd0);
      end
      req = 16'h0000;

      // Backpressure after beat 2
      do_reset();
      req = 16'h0008;
      step();
      check_grant("bp_grant", 3, 0);
      step();
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_grant("bp_hold", 3, 2);
      end
      out_ready = 1'b1;
      step();
      check_grant("bp_beat3", 3, 3);
      step();
      check_idle("bp_rel");
      check("bp_total", 32'(beat_cnt), 32'd4);
      req = 16'h0000;

      // Abort of grant to 7 after one beat, next grant 9
      do_reset();
      req = 16'h0080;
      step();
      check_grant("ab_grant", 7, 0);
      step();
      check("ab_beat1", 32'(beat_cnt), 32'd1);
      req = 16'h0200;
      step();
      check_idle("ab_rel");
      check("ab_cnt", 32'(beat_cnt), 32'd1);
      step();
      check_grant("ab_next", 9, 0);
      req = 16'h0000;

      // Reset during beat 2 of grant to 10
      do_reset();
      req = 16'h1400;
      step();
      check_grant("mr_grant", 10, 0);
      step();
      rst_n = 1'b0;
      step();
      check("mr_gnt",   32'(gnt),       32'd0);
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_sel",   32'(sel),       32'd0);
      check("mr_cnt",   32'(beat_cnt),  32'd0);
      rst_n = 1'b1;
      step();
      check_grant("mr_regrant", 10, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
